// File: rtl/riscat_pkg.sv
// Shared register-file types and constants for the writeback path.
package riscat_pkg;
    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, rotating priority pointer.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_win;
    logic          w_found;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        int idx;
        idx     = 0;
        w_win   = '0;
        w_found = 1'b0;
        gnt     = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_win   = PW'(idx);
            end
        end
        if (w_found) begin
            gnt[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (advance && w_found) begin
            r_ptr <= (w_win == PW'(N - 1)) ? '0 : w_win + PW'(1);
        end
    end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between result producers; one registered
// write per cycle, round-robin fairness, writes to x0 consumed but dropped.
module regfile_wr_arbiter
    import riscat_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wb_stall,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      reg_wr_en,
    output logic [ADDR_W-1:0]         reg_wr_addr,
    output logic [DATA_W-1:0]         reg_wr_data,
    output logic [ID_W-1:0]           grant_id
);
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_accept;
    logic [ADDR_W-1:0]  w_addr_slice [NUM_REQ];
    logic [DATA_W-1:0]  w_data_slice [NUM_REQ];
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic [ID_W-1:0]    w_sel_id;
    logic               w_do_write;

    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic [ID_W-1:0]    r_grant_id;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_valid),
        .advance (w_accept),
        .gnt     (w_gnt)
    );

    // Grants are suppressed while the register file is busy or in reset.
    assign req_ready = (reset_n && !wb_stall) ? w_gnt : '0;
    assign w_accept  = |req_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign w_addr_slice[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign w_data_slice[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_id   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sel_addr = w_sel_addr | (w_addr_slice[i] & {ADDR_W{req_ready[i]}});
            w_sel_data = w_sel_data | (w_data_slice[i] & {DATA_W{req_ready[i]}});
            if (req_ready[i]) begin
                w_sel_id = ID_W'(i);
            end
        end
    end

    // x0 requests still consume the slot but never reach the register file.
    assign w_do_write = w_accept && (w_sel_addr != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_grant_id <= '0;
        end else begin
            r_wr_en <= w_do_write;
            if (w_do_write) begin
                r_wr_addr  <= w_sel_addr;
                r_wr_data  <= w_sel_data;
                r_grant_id <= w_sel_id;
            end
        end
    end

    assign reg_wr_en   = r_wr_en;
    assign reg_wr_addr = r_wr_addr;
    assign reg_wr_data = r_wr_data;
    assign grant_id    = r_grant_id;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized and directed bench for regfile_wr_arbiter against a queue-based model.
module tb_regfile_wr_arbiter;
    localparam int NR = 2;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int IW = $clog2(NR);

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } item_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             wb_stall;
    logic [NR-1:0]    req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             reg_wr_en;
    logic [AW-1:0]    reg_wr_addr;
    logic [DW-1:0]    reg_wr_data;
    logic [IW-1:0]    grant_id;

    regfile_wr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wb_stall    (wb_stall),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: pending items per source, pointer, expected write port.
    item_t         src_q [NR][$];
    int            m_ptr;
    logic          m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_gid;
    logic [NR-1:0] last_rdy;
    logic [AW-1:0] wr_log [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int winner(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++)
            if (v[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    task automatic run_cycle();
        int w;
        logic [NR-1:0] exp_rdy;
        item_t it;
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = (src_q[i].size() > 0);
            if (req_valid[i]) begin
                req_addr[i*AW +: AW] = src_q[i][0].a;
                req_data[i*DW +: DW] = src_q[i][0].d;
            end
        end
        @(negedge clk);
        w = (reset_n && !wb_stall) ? winner(req_valid, m_ptr) : -1;
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        check("ready", 64'(req_ready), 64'(exp_rdy));
        last_rdy = req_ready;
        @(posedge clk);
        if (!reset_n) begin
            m_en = 0; m_addr = '0; m_data = '0; m_gid = 0; m_ptr = 0;
        end else if (w >= 0) begin
            it    = src_q[w].pop_front();
            m_ptr = (w + 1) % NR;
            m_en  = (it.a != 0);
            if (m_en) begin
                m_addr = it.a; m_data = it.d; m_gid = w;
            end
        end else begin
            m_en = 0;
        end
        #1;
        check("wr_en", 64'(reg_wr_en), 64'(m_en));
        check("wr_addr", 64'(reg_wr_addr), 64'(m_addr));
        check("wr_data", 64'(reg_wr_data), 64'(m_data));
        check("grant_id", 64'(grant_id), 64'(m_gid));
        $display("cyc t=%0t rst_n=%0b stall=%0b valid=%b ready=%b wr_en=%0b addr=%0d data=%h gid=%0d",
                 $time, reset_n, wb_stall, req_valid, req_ready, reg_wr_en, reg_wr_addr, reg_wr_data, grant_id);
        if (reg_wr_en) wr_log.push_back(reg_wr_addr);
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NR; i++) src_q[i].delete();
    endtask

    initial begin
        reset_n = 1'b0; wb_stall = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0;
        m_ptr = 0; m_en = 0; m_addr = '0; m_data = '0; m_gid = 0;

        // Reset with every requester valid: no grants, outputs zero.
        for (int i = 0; i < NR; i++) src_q[i].push_back('{a: AW'(i + 3), d: 32'h1111_0000 + DW'(i)});
        repeat (3) begin
            run_cycle();
            check("rst_ready", 64'(last_rdy), 64'(0));
        end
        clear_queues();
        reset_n = 1'b1;
        run_cycle();

        // Single source.
        src_q[0].push_back('{a: 5'd5, d: 32'hDEADBEEF});
        run_cycle();
        check("single_ready", 64'(last_rdy), 64'(2'b01));
        check("single_data", 64'(reg_wr_data), 64'(32'hDEADBEEF));
        check("single_gid", 64'(grant_id), 64'(0));

        // Contention from pointer 0.
        reset_n = 1'b0; run_cycle(); reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            src_q[0].push_back('{a: AW'(1 + k), d: DW'(32'hA000 + k)});
            src_q[1].push_back('{a: AW'(9 + k), d: DW'(32'hB000 + k)});
        end
        wr_log.delete();
        repeat (4) run_cycle();
        check("order_n", 64'(wr_log.size()), 64'(4));
        if (wr_log.size() == 4) begin
            check("order0", 64'(wr_log[0]), 64'(1));
            check("order1", 64'(wr_log[1]), 64'(9));
            check("order2", 64'(wr_log[2]), 64'(2));
            check("order3", 64'(wr_log[3]), 64'(10));
        end
        clear_queues();

        // x0 drop advances the pointer.
        reset_n = 1'b0; run_cycle(); reset_n = 1'b1;
        src_q[0].push_back('{a: 5'd0, d: 32'h55});
        run_cycle();
        check("x0_ready", 64'(last_rdy), 64'(2'b01));
        check("x0_wr_en", 64'(reg_wr_en), 64'(0));
        src_q[0].push_back('{a: 5'd3, d: 32'h33});
        src_q[1].push_back('{a: 5'd4, d: 32'h44});
        run_cycle();
        check("x0_ptr", 64'(last_rdy), 64'(2'b10));

        // Stall with both valid; pointer is 0 here, so grant resumes at 0.
        src_q[1].push_back('{a: 5'd6, d: 32'h66});
        wb_stall = 1'b1;
        repeat (2) begin
            run_cycle();
            check("stall_ready", 64'(last_rdy), 64'(0));
        end
        wb_stall = 1'b0;
        run_cycle();
        check("stall_resume", 64'(last_rdy), 64'(2'b01));
        clear_queues();
        run_cycle();

        // Reset arriving with a pending ALU request: nothing is written.
        src_q[0].push_back('{a: 5'd7, d: 32'h77});
        reset_n = 1'b0;
        run_cycle();
        check("midrst_en", 64'(reg_wr_en), 64'(0));
        check("midrst_addr", 64'(reg_wr_addr), 64'(0));
        clear_queues();
        reset_n = 1'b1;

        // Randomized traffic with occasional stalls and resets.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NR; i++)
                if (src_q[i].size() == 0 && ($urandom % 2) == 0)
                    src_q[i].push_back('{a: (($urandom % 8) == 0) ? AW'(0) : AW'($urandom),
                                        d: DW'($urandom)});
            wb_stall = (($urandom % 5) == 0);
            reset_n  = (($urandom % 50) != 0);
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
